// File: rtl/ap_pkg.sv
// Shared constants for the AP CAM engine: opcodes, tag-accumulate modes,
// FSM encodings and the ceil-log2 helper used to size address fields.
package ap_pkg;
  localparam logic [2:0] OP_WRITE        = 3'd0;
  localparam logic [2:0] OP_READ         = 3'd1;
  localparam logic [2:0] OP_COMPARE      = 3'd2;
  localparam logic [2:0] OP_WRITE_TAGGED = 3'd3;
  localparam logic [2:0] OP_SCAN         = 3'd4;
  localparam logic [2:0] OP_CLEAR_TAGS   = 3'd5;
  localparam logic [2:0] OP_NOP          = 3'd6;

  localparam logic [1:0] ACC_REPLACE = 2'd0;
  localparam logic [1:0] ACC_AND     = 2'd1;
  localparam logic [1:0] ACC_OR      = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_SCAN} state_e;

  // ceil(log2(n)), never less than 1 so a 1-bit address is still legal
  function automatic int clogb2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/ap_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest 1 plus an any-set flag.
module ap_prio_enc #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec_i[i]) idx_o = IW'(i);
  end

  assign any_o = |vec_i;
endmodule

// File: rtl/ap_cam_engine.sv
// Command-driven associative CAM: masked write/read, tag-accumulating compare,
// tag-guided parallel write and a per-address scan of the tag vector.
module ap_cam_engine import ap_pkg::*; #(
  parameter  int WORD_SIZE  = 8,
  parameter  int CELL_QUANT = 512,
  localparam int ADDR_BITS  = clogb2(CELL_QUANT)
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [1:0]            cmd_acc,
  input  logic [ADDR_BITS-1:0]  cmd_addr,
  input  logic [WORD_SIZE-1:0]  cmd_data,
  input  logic [WORD_SIZE-1:0]  cmd_key,
  input  logic [WORD_SIZE-1:0]  cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_SIZE-1:0]  rsp_data,
  output logic [ADDR_BITS-1:0]  rsp_addr,
  output logic                  rsp_hit,
  output logic                  rsp_last,
  output logic [ADDR_BITS:0]    match_count,
  output logic [CELL_QUANT-1:0] tags
);
  localparam int CW = ADDR_BITS + 1;

  state_e                               state_q, state_d;
  logic [CELL_QUANT-1:0][WORD_SIZE-1:0] words_q;
  logic [CELL_QUANT-1:0]                tags_q, tags_d, scan_q, scan_d;
  logic [CELL_QUANT-1:0]                match, cmp_tags;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]                 rdata_q, rdata_d;
  logic [ADDR_BITS-1:0]                 raddr_q, raddr_d, cmp_idx, scan_idx;
  logic                                 rhit_q, rhit_d, rlast_q, rlast_d;
  logic                                 cmp_any, scan_any, scan_last, accept, addr_ok;

  function automatic logic [CW-1:0] popcnt(input logic [CELL_QUANT-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < CELL_QUANT; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  always_comb begin
    for (int i = 0; i < CELL_QUANT; i++)
      match[i] = ((words_q[i] ^ cmd_key) & cmd_mask) == '0;
  end

  always_comb begin
    case (cmd_acc)
      ACC_AND: cmp_tags = tags_q & match;
      ACC_OR:  cmp_tags = tags_q | match;
      default: cmp_tags = match;
    endcase
  end

  ap_prio_enc #(.N(CELL_QUANT), .IW(ADDR_BITS)) u_cmp_enc (
    .vec_i(cmp_tags), .idx_o(cmp_idx), .any_o(cmp_any)
  );

  ap_prio_enc #(.N(CELL_QUANT), .IW(ADDR_BITS)) u_scan_enc (
    .vec_i(scan_q), .idx_o(scan_idx), .any_o(scan_any)
  );

  // An empty scan vector still yields one terminating response
  assign scan_last = !scan_any || ((scan_q & (scan_q - CELL_QUANT'(1))) == '0);
  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign addr_ok   = int'(cmd_addr) < CELL_QUANT;

  always_comb begin
    state_d = state_q;
    tags_d  = tags_q;
    cnt_d   = cnt_q;
    scan_d  = scan_q;
    rdata_d = rdata_q;
    raddr_d = raddr_q;
    rhit_d  = rhit_q;
    rlast_d = rlast_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        state_d = (cmd_op == OP_SCAN) ? ST_SCAN : ST_RESP;
        rdata_d = '0;
        raddr_d = '0;
        rhit_d  = 1'b0;
        rlast_d = 1'b1;
        case (cmd_op)
          OP_WRITE: raddr_d = cmd_addr;
          OP_READ: begin
            raddr_d = cmd_addr;
            if (addr_ok) rdata_d = words_q[cmd_addr];
          end
          OP_COMPARE: begin
            tags_d  = cmp_tags;
            cnt_d   = popcnt(cmp_tags);
            rhit_d  = cmp_any;
            raddr_d = cmp_idx;
          end
          OP_WRITE_TAGGED: rhit_d = |tags_q;
          OP_SCAN:         scan_d = tags_q;
          OP_CLEAR_TAGS: begin
            tags_d = '0;
            cnt_d  = '0;
          end
          default: ;
        endcase
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      ST_SCAN: if (rsp_ready) begin
        scan_d = scan_q & (scan_q - CELL_QUANT'(1));
        if (scan_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      words_q <= '0;
      tags_q  <= '0;
      scan_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      raddr_q <= '0;
      rhit_q  <= 1'b0;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tags_q  <= tags_d;
      scan_q  <= scan_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      raddr_q <= raddr_d;
      rhit_q  <= rhit_d;
      rlast_q <= rlast_d;
      // Out-of-range addresses never equal any i, so such writes drop out
      for (int i = 0; i < CELL_QUANT; i++)
        if (accept && ((cmd_op == OP_WRITE && int'(cmd_addr) == i) ||
                       (cmd_op == OP_WRITE_TAGGED && tags_q[i])))
          words_q[i] <= (words_q[i] & ~cmd_mask) | (cmd_data & cmd_mask);
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q != ST_IDLE);
  assign rsp_data    = (state_q == ST_SCAN) ? '0        : rdata_q;
  assign rsp_addr    = (state_q == ST_SCAN) ? scan_idx  : raddr_q;
  assign rsp_hit     = (state_q == ST_SCAN) ? scan_any  : rhit_q;
  assign rsp_last    = (state_q == ST_SCAN) ? scan_last : rlast_q;
  assign match_count = cnt_q;
  assign tags        = tags_q;
endmodule

// File: tb/tb_ap_cam_engine.sv
// Scoreboard bench for ap_cam_engine with 8 words of 8 bits.
module tb_ap_cam_engine;
  localparam int WS = 8;
  localparam int CQ = 8;
  localparam int AB = 3;

  typedef struct packed {
    logic [WS-1:0] data;
    logic [AB-1:0] addr;
    logic          hit;
    logic          last;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [1:0]    cmd_acc = '0;
  logic [AB-1:0] cmd_addr = '0;
  logic [WS-1:0] cmd_data = '0, cmd_key = '0, cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [WS-1:0] rsp_data;
  logic [AB-1:0] rsp_addr;
  logic          rsp_hit, rsp_last;
  logic [AB:0]   match_count;
  logic [CQ-1:0] tags;

  always #5 clk = ~clk;

  ap_cam_engine #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (
    .CLK100MHZ(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_acc(cmd_acc),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_key(cmd_key), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_hit(rsp_hit), .rsp_last(rsp_last), .match_count(match_count), .tags(tags)
  );

  rsp_t expq[$];
  int   checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  rsp_t held;
  logic stalled = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: compare each handshaken response against the scoreboard head
  always @(negedge clk) begin
    rsp_t got, e;
    got = {rsp_data, rsp_addr, rsp_hit, rsp_last};
    if (!rsp_valid) stalled = 1'b0;
    else begin
      if (stalled) begin
        checks++;
        if (got !== held) begin
          errors++;
          $display("FAIL stall_stable got=%h held=%h", got, held);
        end
      end
      if (rsp_ready) begin
        stalled = 1'b0;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL extra_rsp got data=%h addr=%0d hit=%b last=%b",
                   got.data, got.addr, got.hit, got.last);
        end else begin
          e = expq.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL rsp got data=%h addr=%0d hit=%b last=%b want data=%h addr=%0d hit=%b last=%b",
                     got.data, got.addr, got.hit, got.last, e.data, e.addr, e.hit, e.last);
          end
        end
      end else begin
        stalled = 1'b1;
        held    = got;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [WS-1:0] d, input logic [AB-1:0] a, input logic h, input logic l);
    expq.push_back({d, a, h, l});
  endtask

  // Called at a negedge; returns at the negedge after accept
  task automatic send(input logic [2:0] o, input logic [1:0] a, input logic [AB-1:0] ad,
                      input logic [WS-1:0] d, input logic [WS-1:0] k, input logic [WS-1:0] m);
    int n;
    n = 0;
    cmd_op = o; cmd_acc = a; cmd_addr = ad; cmd_data = d; cmd_key = k; cmd_mask = m;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%0d", o);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      acc_cyc = cyc;
      @(negedge clk);
      chk("rsp_latency", 32'(rsp_valid), 32'd1);
    end
  endtask

  task automatic op(input logic [2:0] o, input logic [1:0] a, input logic [AB-1:0] ad,
                    input logic [WS-1:0] d, input logic [WS-1:0] k, input logic [WS-1:0] m,
                    input logic [WS-1:0] ed, input logic [AB-1:0] ea, input logic eh, input logic el);
    push(ed, ea, eh, el);
    send(o, a, ad, d, k, m);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d want=0", expq.size());
    end
  endtask

  task automatic setrdy(input logic v);
    @(posedge clk);
    #1 rsp_ready = v;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WS-1:0] w4 [4];
    int prev;
    w4 = '{8'h10, 8'h91, 8'hA0, 8'h91};
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    // Put state in place, then reset while a SCAN response is stalled
    op(3'd0, 2'd0, 3'd2, 8'h55, 8'h00, 8'hFF, 8'h00, 3'd2, 1'b0, 1'b1);
    op(3'd2, 2'd0, 3'd0, 8'h00, 8'h55, 8'hFF, 8'h00, 3'd2, 1'b1, 1'b1);
    drain();
    chk("tags_pre", 32'(tags), 32'h04);
    chk("mc_pre", 32'(match_count), 32'd1);
    setrdy(1'b0);
    push(8'h00, 3'd2, 1'b1, 1'b1);
    send(3'd4, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    expq.delete();
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    setrdy(1'b1);
    chk("rst_rsp_valid_rel", 32'(rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_tags", 32'(tags), 32'h00);
    chk("rst_mc", 32'(match_count), 32'd0);
    op(3'd1, 2'd0, 3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b1);
    op(3'd1, 2'd0, 3'd3, 8'h00, 8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b1);

    // Masked write then read back
    op(3'd0, 2'd0, 3'd3, 8'hA5, 8'h00, 8'hFF, 8'h00, 3'd3, 1'b0, 1'b1);
    op(3'd0, 2'd0, 3'd3, 8'h0F, 8'h00, 8'h0F, 8'h00, 3'd3, 1'b0, 1'b1);
    op(3'd1, 2'd0, 3'd3, 8'h00, 8'h00, 8'h00, 8'hAF, 3'd3, 1'b0, 1'b1);

    // Compare with replace / AND / OR accumulation
    op(3'd0, 2'd0, 3'd0, 8'h10, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b1);
    op(3'd0, 2'd0, 3'd1, 8'h11, 8'h00, 8'hFF, 8'h00, 3'd1, 1'b0, 1'b1);
    op(3'd0, 2'd0, 3'd2, 8'h20, 8'h00, 8'hFF, 8'h00, 3'd2, 1'b0, 1'b1);
    op(3'd0, 2'd0, 3'd3, 8'h11, 8'h00, 8'hFF, 8'h00, 3'd3, 1'b0, 1'b1);
    op(3'd2, 2'd0, 3'd0, 8'h00, 8'h11, 8'hFF, 8'h00, 3'd1, 1'b1, 1'b1);
    drain();
    chk("cmp_rep_tags", 32'(tags), 32'h0A);
    chk("cmp_rep_mc", 32'(match_count), 32'd2);
    op(3'd2, 2'd1, 3'd0, 8'h00, 8'h01, 8'h0F, 8'h00, 3'd1, 1'b1, 1'b1);
    drain();
    chk("cmp_and_tags", 32'(tags), 32'h0A);
    op(3'd2, 2'd2, 3'd0, 8'h00, 8'h20, 8'hFF, 8'h00, 3'd1, 1'b1, 1'b1);
    drain();
    chk("cmp_or_tags", 32'(tags), 32'h0E);
    chk("cmp_or_mc", 32'(match_count), 32'd3);

    // Tag-guided parallel write
    op(3'd3, 2'd0, 3'd0, 8'h80, 8'h00, 8'h80, 8'h00, 3'd0, 1'b1, 1'b1);
    op(3'd1, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h10, 3'd0, 1'b0, 1'b1);
    op(3'd1, 2'd0, 3'd1, 8'h00, 8'h00, 8'h00, 8'h91, 3'd1, 1'b0, 1'b1);
    op(3'd1, 2'd0, 3'd2, 8'h00, 8'h00, 8'h00, 8'hA0, 3'd2, 1'b0, 1'b1);
    op(3'd1, 2'd0, 3'd3, 8'h00, 8'h00, 8'h00, 8'h91, 3'd3, 1'b0, 1'b1);
    op(3'd1, 2'd0, 3'd4, 8'h00, 8'h00, 8'h00, 8'h00, 3'd4, 1'b0, 1'b1);
    drain();
    chk("wt_tags", 32'(tags), 32'h0E);

    // Stalled scan, then scan of an empty tag vector
    setrdy(1'b0);
    push(8'h00, 3'd1, 1'b1, 1'b0);
    push(8'h00, 3'd2, 1'b1, 1'b0);
    push(8'h00, 3'd3, 1'b1, 1'b1);
    send(3'd4, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    setrdy(1'b1);
    drain();
    chk("scan_tags", 32'(tags), 32'h0E);
    chk("scan_mc", 32'(match_count), 32'd3);
    op(3'd5, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    drain();
    chk("clr_tags", 32'(tags), 32'h00);
    chk("clr_mc", 32'(match_count), 32'd0);
    op(3'd4, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    drain();

    // NOP leaves state alone
    op(3'd2, 2'd0, 3'd0, 8'h00, 8'h91, 8'hFF, 8'h00, 3'd1, 1'b1, 1'b1);
    op(3'd7, 2'd2, 3'd5, 8'hFF, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b1);
    drain();
    chk("nop_tags", 32'(tags), 32'h0A);
    chk("nop_mc", 32'(match_count), 32'd2);
    op(3'd1, 2'd0, 3'd5, 8'h00, 8'h00, 8'h00, 8'h00, 3'd5, 1'b0, 1'b1);
    drain();

    // Back-to-back commands: one accept every 2 cycles
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      op(3'd1, 2'd0, AB'(k), 8'h00, 8'h00, 8'h00, w4[k], AB'(k), 1'b0, 1'b1);
      if (k > 0) chk("throughput_gap", 32'(acc_cyc - prev), 32'd2);
      prev = acc_cyc;
    end
    push(8'h00, 3'd1, 1'b1, 1'b0);
    push(8'h00, 3'd3, 1'b1, 1'b1);
    send(3'd4, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00);
    drain();
    chk("queue_empty", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
